uart_loopback_core: RTL and testbench

Parametrised UART transmitter/receiver pair with selectable internal loopback. It is the successor to the fixed 8-bit Tx→Rx loopback top, adding configurable data width, baud divisor, optional parity, a valid/ready transmit handshake, framing/parity error reporting and external-line operation. It sits between a byte-level client and the serial pins, and doubles as a self-test path when loopback is selected.

---
 rtl/uart_pkg.sv | 34 +++
 rtl/uart_rx.sv | 121 ++++++++++++
 rtl/uart_tx.sv | 109 ++++++++++
 rtl/uart_loopback_core.sv | 71 +++++++
 tb/tb_uart_loopback_core.sv | 205 ++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART TX/RX pair: parity mode encoding,
// FSM state encodings and the parity helper used by both directions.
package uart_pkg;

  // Parity mode encoding (value XORed into the data parity).
  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  // Widest payload supported; parity_calc works on a zero-extended word.
  localparam int MAX_DATA_BITS = 9;

  // TX FSM states.
  typedef logic [2:0] tx_state_t;
  localparam tx_state_t TX_IDLE   = 3'd0;
  localparam tx_state_t TX_START  = 3'd1;
  localparam tx_state_t TX_DATA   = 3'd2;
  localparam tx_state_t TX_PARITY = 3'd3;
  localparam tx_state_t TX_STOP   = 3'd4;

  // RX FSM states.
  typedef logic [2:0] rx_state_t;
  localparam rx_state_t RX_IDLE   = 3'd0;
  localparam rx_state_t RX_START  = 3'd1;
  localparam rx_state_t RX_DATA   = 3'd2;
  localparam rx_state_t RX_PARITY = 3'd3;
  localparam rx_state_t RX_STOP   = 3'd4;

  // Parity bit for a word; zero extension does not change the XOR.
  function automatic logic parity_calc(input logic [MAX_DATA_BITS-1:0] data,
                                       input logic odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/uart_rx.sv
// UART receiver: 2-flop synchroniser, start-edge detection with mid-bit
// glitch rejection, LSB-first data capture, parity and framing checks.
module uart_rx
  import uart_pkg::*;
#(
  parameter int DATA_BITS    = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY_EN    = 1,
  parameter int PARITY_ODD   = 0
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 rxd,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 parity_err,
  output logic                 frame_err,
  output rx_state_t            rx_state
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(DATA_BITS);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] IDX_LAST  = BW'(DATA_BITS - 1);
  localparam logic PAR_MODE = (PARITY_ODD != 0) ? PAR_ODD : PAR_EVEN;

  logic [1:0]           sync_q;
  logic                 rxs;
  logic [CW-1:0]        cnt;
  logic [BW-1:0]        idx;
  logic [DATA_BITS-1:0] shreg;
  logic                 rx_par;
  logic                 wait_high;

  assign rxs = sync_q[1];

  // Two-flop synchroniser for the asynchronous line; resets to idle-high.
  always_ff @(posedge Clk) begin
    if (Reset) sync_q <= 2'b11;
    else       sync_q <= {sync_q[0], rxd};
  end

  // Receive sequencer; rx_valid is a one-cycle pulse on the stop sample.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      rx_state   <= RX_IDLE;
      cnt        <= '0;
      idx        <= '0;
      shreg      <= '0;
      rx_par     <= 1'b0;
      wait_high  <= 1'b0;
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      case (rx_state)
        RX_IDLE: begin
          // After a framing error the line must return high before re-arming.
          if (wait_high) begin
            if (rxs) wait_high <= 1'b0;
          end else if (!rxs) begin
            cnt      <= '0;
            rx_state <= RX_START;
          end
        end
        RX_START: begin
          if (cnt == HALF_LAST) begin
            cnt <= '0;
            idx <= '0;
            if (rxs) rx_state <= RX_IDLE;
            else     rx_state <= RX_DATA;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RX_DATA: begin
          if (cnt == BIT_LAST) begin
            cnt   <= '0;
            shreg <= {rxs, shreg[DATA_BITS-1:1]};
            if (idx == IDX_LAST) begin
              if (PARITY_EN != 0) rx_state <= RX_PARITY;
              else                rx_state <= RX_STOP;
            end else begin
              idx <= idx + 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RX_PARITY: begin
          if (cnt == BIT_LAST) begin
            cnt      <= '0;
            rx_par   <= rxs;
            rx_state <= RX_STOP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RX_STOP: begin
          if (cnt == BIT_LAST) begin
            cnt        <= '0;
            rx_data    <= shreg;
            parity_err <= (PARITY_EN != 0) &&
                          (parity_calc(MAX_DATA_BITS'(shreg), PAR_MODE) != rx_par);
            frame_err  <= !rxs;
            wait_high  <= !rxs;
            rx_valid   <= 1'b1;
            rx_state   <= RX_IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: rx_state <= RX_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: accepts a word in IDLE, then serialises start, data
// (LSB first), optional parity and stop bits, each held CLKS_PER_BIT cycles.
module uart_tx
  import uart_pkg::*;
#(
  parameter int DATA_BITS    = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY_EN    = 1,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 txd,
  output tx_state_t            tx_state
);

  localparam int CNT_MAX = STOP_BITS * CLKS_PER_BIT;
  localparam int CW      = $clog2(CNT_MAX);
  localparam int BW      = $clog2(DATA_BITS);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] STOP_LAST = CW'(CNT_MAX - 1);
  localparam logic [BW-1:0] IDX_LAST  = BW'(DATA_BITS - 1);
  localparam logic PAR_MODE = (PARITY_ODD != 0) ? PAR_ODD : PAR_EVEN;

  logic [CW-1:0]        cnt;
  logic [BW-1:0]        idx;
  logic [DATA_BITS-1:0] shreg;
  logic                 par;

  // Frame sequencer: txd is registered so it changes the cycle after acceptance.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      tx_state <= TX_IDLE;
      cnt      <= '0;
      idx      <= '0;
      shreg    <= '0;
      par      <= 1'b0;
      txd      <= 1'b1;
    end else begin
      case (tx_state)
        TX_IDLE: begin
          if (tx_valid) begin
            shreg    <= tx_data;
            par      <= parity_calc(MAX_DATA_BITS'(tx_data), PAR_MODE);
            txd      <= 1'b0;
            cnt      <= '0;
            tx_state <= TX_START;
          end
        end
        TX_START: begin
          if (cnt == BIT_LAST) begin
            cnt      <= '0;
            idx      <= '0;
            txd      <= shreg[0];
            shreg    <= shreg >> 1;
            tx_state <= TX_DATA;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        TX_DATA: begin
          if (cnt == BIT_LAST) begin
            cnt <= '0;
            if (idx == IDX_LAST) begin
              if (PARITY_EN != 0) begin
                txd      <= par;
                tx_state <= TX_PARITY;
              end else begin
                txd      <= 1'b1;
                tx_state <= TX_STOP;
              end
            end else begin
              idx   <= idx + 1'b1;
              txd   <= shreg[0];
              shreg <= shreg >> 1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        TX_PARITY: begin
          if (cnt == BIT_LAST) begin
            cnt      <= '0;
            txd      <= 1'b1;
            tx_state <= TX_STOP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        TX_STOP: begin
          if (cnt == STOP_LAST) begin
            cnt      <= '0;
            tx_state <= TX_IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          tx_state <= TX_IDLE;
          txd      <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: rtl/uart_loopback_core.sv
// UART TX/RX pair with selectable internal loopback.
// Handshake: a word transfers on the rising Clk edge where tx_valid and
// tx_ready are both high; tx_ready is high only while the TX FSM is IDLE,
// and tx_data must be stable whenever tx_valid is high and tx_ready is high.
module uart_loopback_core
  import uart_pkg::*;
#(
  parameter int DATA_BITS    = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY_EN    = 1,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 tx_busy,
  output logic                 txd_out,
  input  logic                 rxd_in,
  input  logic                 loopback,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 rx_idle
);

  tx_state_t tx_state;
  rx_state_t rx_state;
  logic      rx_line;

  assign tx_ready = (tx_state == TX_IDLE);
  assign tx_busy  = !tx_ready;
  assign rx_idle  = (rx_state == RX_IDLE);
  // The pin is always driven; loopback only redirects what the receiver hears.
  assign rx_line  = loopback ? txd_out : rxd_in;

  uart_tx #(
    .DATA_BITS   (DATA_BITS),
    .CLKS_PER_BIT(CLKS_PER_BIT),
    .PARITY_EN   (PARITY_EN),
    .PARITY_ODD  (PARITY_ODD),
    .STOP_BITS   (STOP_BITS)
  ) u_tx (
    .Clk     (Clk),
    .Reset   (Reset),
    .tx_data (tx_data),
    .tx_valid(tx_valid),
    .txd     (txd_out),
    .tx_state(tx_state)
  );

  uart_rx #(
    .DATA_BITS   (DATA_BITS),
    .CLKS_PER_BIT(CLKS_PER_BIT),
    .PARITY_EN   (PARITY_EN),
    .PARITY_ODD  (PARITY_ODD)
  ) u_rx (
    .Clk       (Clk),
    .Reset     (Reset),
    .rxd       (rx_line),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .parity_err(parity_err),
    .frame_err (frame_err),
    .rx_state  (rx_state)
  );

endmodule

// File: tb/tb_uart_loopback_core.sv
// Directed bench for uart_loopback_core at 8 data bits, 4 clocks/bit, even parity.
module tb_uart_loopback_core;

  localparam int CPB = 4;

  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready, tx_busy, txd_out;
  logic       rxd_in = 1'b1;
  logic       loopback = 1'b1;
  logic [7:0] rx_data;
  logic       rx_valid, parity_err, frame_err, rx_idle;

  int n_checks = 0;
  int n_pass   = 0;
  int rx_cnt   = 0;

  // expected received words: {frame_err, parity_err, data}
  logic [9:0] exp_q[$];

  uart_loopback_core #(
    .DATA_BITS(8), .CLKS_PER_BIT(CPB), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)
  ) dut (
    .Clk(Clk), .Reset(Reset), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .tx_busy(tx_busy), .txd_out(txd_out),
    .rxd_in(rxd_in), .loopback(loopback), .rx_data(rx_data),
    .rx_valid(rx_valid), .parity_err(parity_err), .frame_err(frame_err),
    .rx_idle(rx_idle)
  );

  // clock / watchdog
  always #5 Clk = ~Clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
  endtask

  // scoreboard: every rx_valid pulse must match the next expected word
  always @(negedge Clk) begin
    if (!Reset && rx_valid) begin
      rx_cnt++;
      check("rx_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        logic [9:0] e;
        e = exp_q.pop_front();
        check("rx_word", 32'({frame_err, parity_err, rx_data}), 32'(e));
      end
    end
  end

  // drivers
  task automatic wait_cycles(input int n);
    repeat (n) @(negedge Clk);
  endtask

  task automatic send_serial(input logic [7:0] d, input logic par, input logic stop);
    logic [10:0] bits;
    bits = {stop, par, d, 1'b0};
    for (int i = 0; i < 11; i++) begin
      rxd_in = bits[i];
      repeat (CPB) @(negedge Clk);
    end
  endtask

  initial begin
    logic [10:0] frame;
    int latency;
    int pulses;
    int base;
    bit saw_low, saw_valid, saw_notready, saw_start;

    // ---- reset and idle ----
    wait_cycles(5);
    Reset = 1'b0;
    check("rst_txd", 32'(txd_out), 32'd1);
    check("rst_tx_ready", 32'(tx_ready), 32'd1);
    check("rst_tx_busy", 32'(tx_busy), 32'd0);
    check("rst_rx_idle", 32'(rx_idle), 32'd1);
    check("rst_rx_data", 32'(rx_data), 32'd0);
    check("rst_errs", 32'({parity_err, frame_err}), 32'd0);
    saw_low = 0; saw_valid = 0; saw_notready = 0;
    for (int k = 0; k < 100; k++) begin
      if (!txd_out) saw_low = 1;
      if (rx_valid) saw_valid = 1;
      if (!tx_ready || !rx_idle) saw_notready = 1;
      @(negedge Clk);
    end
    check("idle_txd_low", 32'(saw_low), 32'd0);
    check("idle_rx_valid", 32'(saw_valid), 32'd0);
    check("idle_not_ready", 32'(saw_notready), 32'd0);

    // ---- loopback 0xA5: bit sequence and latency ----
    frame = 11'b1_0_10100101_0;
    exp_q.push_back({1'b0, 1'b0, 8'hA5});
    check("a5_ready_pre", 32'(tx_ready), 32'd1);
    tx_data = 8'hA5; tx_valid = 1'b1;
    @(negedge Clk);
    tx_valid = 1'b0;
    latency = -1; pulses = 0;
    for (int k = 0; k <= 50; k++) begin
      if (k % CPB == 2 && k / CPB < 11) check("a5_txd_bit", 32'(txd_out), 32'(frame[k / CPB]));
      if (k == 1) check("a5_busy", 32'(tx_busy), 32'd1);
      if (rx_valid) begin
        pulses++;
        if (latency < 0) latency = k;
      end
      @(negedge Clk);
    end
    check("a5_latency", 32'(latency), 32'd45);
    check("a5_pulse_width", 32'(pulses), 32'd1);
    check("a5_hold_data", 32'(rx_data), 32'h0000_00A5);

    // ---- back-to-back 0x00 then 0xFF with tx_valid held ----
    exp_q.push_back({1'b0, 1'b0, 8'h00});
    exp_q.push_back({1'b0, 1'b0, 8'hFF});
    base = rx_cnt;
    tx_data = 8'h00; tx_valid = 1'b1;
    @(negedge Clk);
    tx_data = 8'hFF;
    for (int k = 0; k <= 95; k++) begin
      if (k == 38) check("b2b_par0", 32'(txd_out), 32'd0);
      if (k == 43) check("b2b_ready_43", 32'(tx_ready), 32'd0);
      if (k == 44) begin
        check("b2b_ready_44", 32'(tx_ready), 32'd1);
        check("b2b_txd_44", 32'(txd_out), 32'd1);
      end
      if (k == 45) begin
        check("b2b_accept", 32'(tx_ready), 32'd0);
        check("b2b_start", 32'(txd_out), 32'd0);
        tx_valid = 1'b0;
      end
      if (k == 83) check("b2b_par1", 32'(txd_out), 32'd0);
      @(negedge Clk);
    end
    check("b2b_rx_count", 32'(rx_cnt - base), 32'd2);

    // ---- external line: bad parity, then framing error with stuck-low line ----
    wait_cycles(4);
    loopback = 1'b0;
    base = rx_cnt;
    exp_q.push_back({1'b0, 1'b1, 8'h3C});
    send_serial(8'h3C, 1'b1, 1'b1);
    wait_cycles(20);
    check("par_rx_count", 32'(rx_cnt - base), 32'd1);
    check("par_err_hold", 32'(parity_err), 32'd1);

    exp_q.push_back({1'b1, 1'b0, 8'h3C});
    send_serial(8'h3C, 1'b0, 1'b0);
    wait_cycles(60);
    check("frm_rx_count", 32'(rx_cnt - base), 32'd2);
    check("frm_idle_low", 32'(rx_idle), 32'd1);
    rxd_in = 1'b1;
    wait_cycles(20);
    check("frm_no_repeat", 32'(rx_cnt - base), 32'd2);

    // ---- one-cycle glitch on rxd_in ----
    base = rx_cnt;
    saw_start = 0;
    rxd_in = 1'b0;
    @(negedge Clk);
    rxd_in = 1'b1;
    for (int k = 0; k < 20; k++) begin
      if (!rx_idle) saw_start = 1;
      @(negedge Clk);
    end
    check("glitch_armed", 32'(saw_start), 32'd1);
    check("glitch_idle", 32'(rx_idle), 32'd1);
    check("glitch_no_valid", 32'(rx_cnt - base), 32'd0);

    // ---- reset mid-DATA of a loopback frame ----
    loopback = 1'b1;
    wait_cycles(2);
    base = rx_cnt;
    tx_data = 8'h5A; tx_valid = 1'b1;
    @(negedge Clk);
    tx_valid = 1'b0;
    wait_cycles(12);
    check("rst_mid_busy", 32'(tx_busy), 32'd1);
    Reset = 1'b1;
    @(negedge Clk);
    check("rst_mid_txd", 32'(txd_out), 32'd1);
    check("rst_mid_ready", 32'(tx_ready), 32'd1);
    check("rst_mid_rx_idle", 32'(rx_idle), 32'd1);
    Reset = 1'b0;
    wait_cycles(80);
    check("rst_mid_no_valid", 32'(rx_cnt - base), 32'd0);

    // ---- final report ----
    check("total_rx", 32'(rx_cnt), 32'd5);
    check("exp_q_empty", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
